// File: rtl/guess_evaluator.sv
// Guess evaluator: compares a locked BCD guess against the secret for the round, tracks attempts and win/loss. Optional HINT_DISTANCE_EN adds the hot output.
// Latency: confirm sampled at edge E0, guess latched at E1, result registered at E2, and result_valid pulses in the cycle after E2.
// Backpressure: none; a confirm seen while busy or in a terminal state is dropped, not queued.
module guess_evaluator #(
  parameter int MAX_ATTEMPTS = 7,
  parameter int ATTEMPT_W    = 4,
  parameter int HOT_RANGE    = 10
) (
  input  logic                 clk,
  input  logic                 restart,
  input  logic [1:0]           max_digits,
  input  logic [3:0]           secret_digit_1,
  input  logic [3:0]           secret_digit_2,
  input  logic [3:0]           secret_digit_3,
  input  logic                 secret_valid,
  input  logic                 confirm,
  input  logic [3:0]           compare_digit_1,
  input  logic [3:0]           compare_digit_2,
  input  logic [3:0]           compare_digit_3,
  output logic                 result_valid,
  output logic                 too_low,
  output logic                 too_high,
  output logic                 correct,
  output logic                 invalid_guess,
  output logic [ATTEMPT_W-1:0] attempts_used,
  output logic [ATTEMPT_W-1:0] attempts_left,
  output logic                 game_won,
  output logic                 game_lost,
`ifdef HINT_DISTANCE_EN
  output logic                 busy,
  output logic                 hot
`else
  output logic                 busy
`endif
);

  if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS >= (2 ** ATTEMPT_W) || HOT_RANGE < 0) begin : g_bad_params
    $error("guess_evaluator: parameter out of range");
  end

  localparam logic [ATTEMPT_W-1:0] MAX_A = ATTEMPT_W'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    S_IDLE, S_READY, S_WAIT, S_COMPARE, S_WON, S_LOST
  } state_t;

  state_t state_q, state_d;

  logic [3:0] secret_1_q, secret_2_q, secret_3_q;
  logic [3:0] guess_1_q, guess_2_q, guess_3_q;
  logic       result_valid_q, too_low_q, too_high_q, correct_q, invalid_q;
  logic [ATTEMPT_W-1:0] attempts_used_q;

  // Unused upper digits are zeroed on both sides so they cannot sway the compare.
  logic [1:0]  eff_digits;
  logic        use_2, use_3;
  logic [3:0]  g1, g2, g3, s1, s2, s3;
  logic [11:0] guess_cat, secret_cat;
  logic        guess_invalid, guess_lt, guess_gt, guess_eq;
  logic        at_limit_next;

  always_comb begin
    eff_digits    = (max_digits == 2'd0) ? 2'd1 : max_digits;
    use_2         = (eff_digits >= 2'd2);
    use_3         = (eff_digits == 2'd3);
    g1            = guess_1_q;
    g2            = use_2 ? guess_2_q : 4'd0;
    g3            = use_3 ? guess_3_q : 4'd0;
    s1            = secret_1_q;
    s2            = use_2 ? secret_2_q : 4'd0;
    s3            = use_3 ? secret_3_q : 4'd0;
    guess_cat     = {g3, g2, g1};
    secret_cat    = {s3, s2, s1};
    guess_invalid = (g1 > 4'd9) || (g2 > 4'd9) || (g3 > 4'd9);
    guess_lt      = (guess_cat < secret_cat);
    guess_gt      = (guess_cat > secret_cat);
    guess_eq      = (guess_cat == secret_cat);
    at_limit_next = ((attempts_used_q + 1'b1) == MAX_A);
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (secret_valid) state_d = S_READY;
      S_READY:   if (confirm) state_d = S_WAIT;
      S_WAIT:    state_d = S_COMPARE;
      S_COMPARE: begin
        if (guess_invalid)      state_d = S_READY;
        else if (guess_eq)      state_d = S_WON;
        else if (at_limit_next) state_d = S_LOST;
        else                    state_d = S_READY;
      end
      S_WON:     state_d = S_WON;
      S_LOST:    state_d = S_LOST;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_WAIT) || (state_q == S_COMPARE);
    game_won  = (state_q == S_WON);
    game_lost = (state_q == S_LOST);
  end

`ifdef HINT_DISTANCE_EN
  logic       hot_q;
  logic [9:0] guess_bin, secret_bin, distance;
  logic       hot_d;

  function automatic logic [9:0] bcd_to_bin(input logic [3:0] h, input logic [3:0] t,
                                            input logic [3:0] o);
    return (10'(h) * 10'd100) + (10'(t) * 10'd10) + 10'(o);
  endfunction

  always_comb begin
    guess_bin  = bcd_to_bin(g3, g2, g1);
    secret_bin = bcd_to_bin(s3, s2, s1);
    distance   = (guess_bin >= secret_bin) ? (guess_bin - secret_bin) : (secret_bin - guess_bin);
    hot_d      = !guess_invalid && !guess_eq && (distance <= 10'(HOT_RANGE));
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      hot_q <= 1'b0;
    end else if (state_q == S_COMPARE) begin
      hot_q <= hot_d;
    end
  end

  assign hot = hot_q;
`endif

  always_ff @(posedge clk) begin
    if (restart) begin
      secret_1_q      <= 4'd0;
      secret_2_q      <= 4'd0;
      secret_3_q      <= 4'd0;
      guess_1_q       <= 4'd0;
      guess_2_q       <= 4'd0;
      guess_3_q       <= 4'd0;
      result_valid_q  <= 1'b0;
      too_low_q       <= 1'b0;
      too_high_q      <= 1'b0;
      correct_q       <= 1'b0;
      invalid_q       <= 1'b0;
      attempts_used_q <= '0;
    end else begin
      result_valid_q <= 1'b0;
      if (state_q == S_IDLE && secret_valid) begin
        secret_1_q <= secret_digit_1;
        secret_2_q <= secret_digit_2;
        secret_3_q <= secret_digit_3;
      end
      if (state_q == S_WAIT) begin
        guess_1_q <= compare_digit_1;
        guess_2_q <= compare_digit_2;
        guess_3_q <= compare_digit_3;
      end
      if (state_q == S_COMPARE) begin
        result_valid_q <= 1'b1;
        invalid_q      <= guess_invalid;
        too_low_q      <= !guess_invalid && guess_lt;
        too_high_q     <= !guess_invalid && guess_gt;
        correct_q      <= !guess_invalid && guess_eq;
        if (!guess_invalid && attempts_used_q != MAX_A) begin
          attempts_used_q <= attempts_used_q + 1'b1;
        end
      end
    end
  end

  assign result_valid  = result_valid_q;
  assign too_low       = too_low_q;
  assign too_high      = too_high_q;
  assign correct       = correct_q;
  assign invalid_guess = invalid_q;
  assign attempts_used = attempts_used_q;
  assign attempts_left = MAX_A - attempts_used_q;

endmodule

// File: tb/tb_guess_evaluator.sv
// Bench for guess_evaluator: a default instance (7 attempts) and a 3-attempt instance share stimulus.
module tb_guess_evaluator;

  logic       clk, restart, secret_valid, confirm;
  logic [1:0] max_digits;
  logic [3:0] sd1, sd2, sd3, cd1, cd2, cd3;

  logic       rv0, lo0, hi0, cor0, inv0, won0, lost0, busy0;
  logic [3:0] used0, left0;
  logic       rv3, lo3, hi3, cor3, inv3, won3, lost3, busy3;
  logic [3:0] used3, left3;
`ifdef HINT_DISTANCE_EN
  logic       hot0, hot3;
`endif

  int checks = 0;
  int failures = 0;

  guess_evaluator dut (
    .clk(clk), .restart(restart), .max_digits(max_digits),
    .secret_digit_1(sd1), .secret_digit_2(sd2), .secret_digit_3(sd3),
    .secret_valid(secret_valid), .confirm(confirm),
    .compare_digit_1(cd1), .compare_digit_2(cd2), .compare_digit_3(cd3),
    .result_valid(rv0), .too_low(lo0), .too_high(hi0), .correct(cor0),
    .invalid_guess(inv0), .attempts_used(used0), .attempts_left(left0),
    .game_won(won0), .game_lost(lost0),
`ifdef HINT_DISTANCE_EN
    .busy(busy0), .hot(hot0)
`else
    .busy(busy0)
`endif
  );

  guess_evaluator #(.MAX_ATTEMPTS(3)) dut3 (
    .clk(clk), .restart(restart), .max_digits(max_digits),
    .secret_digit_1(sd1), .secret_digit_2(sd2), .secret_digit_3(sd3),
    .secret_valid(secret_valid), .confirm(confirm),
    .compare_digit_1(cd1), .compare_digit_2(cd2), .compare_digit_3(cd3),
    .result_valid(rv3), .too_low(lo3), .too_high(hi3), .correct(cor3),
    .invalid_guess(inv3), .attempts_used(used3), .attempts_left(left3),
    .game_won(won3), .game_lost(lost3),
`ifdef HINT_DISTANCE_EN
    .busy(busy3), .hot(hot3)
`else
    .busy(busy3)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic [3:0] s1, s2, s3;
    logic [1:0] md;
    logic [3:0] g1, g2, g3;
    logic       lo, hi, cor, inv;
    int         used, left;
    logic       won, lost;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic load_secret(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    restart = 1'b1;
    confirm = 1'b0;
    secret_valid = 1'b0;
    @(posedge clk); #1;
    restart = 1'b0;
    sd1 = a; sd2 = b; sd3 = c;
    secret_valid = 1'b1;
    @(posedge clk); #1;
    secret_valid = 1'b0;
  endtask

  // Returns the number of edges after the confirm edge at which result_valid was seen (0 = none).
  task automatic do_guess(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input bit sel3, output int lat, output logic busy_w);
    cd1 = a; cd2 = b; cd3 = c;
    confirm = 1'b1;
    @(posedge clk); #1;
    confirm = 1'b0;
    busy_w = sel3 ? busy3 : busy0;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (sel3 ? rv3 : rv0) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int   lat;
    logic bw;

    //           rst s1 s2 s3 md  g1 g2 g3  lo hi cor inv used left won lost
    vecs[0]  = '{1, 4, 2, 0, 2,  0, 3, 0,  0, 1, 0, 0,  1, 6, 0, 0};
    vecs[1]  = '{0, 4, 2, 0, 2,  0, 1, 0,  1, 0, 0, 0,  2, 5, 0, 0};
    vecs[2]  = '{0, 4, 2, 0, 2,  0, 2, 0,  1, 0, 0, 0,  3, 4, 0, 0};
    vecs[3]  = '{0, 4, 2, 0, 2,  4, 2, 0,  0, 0, 1, 0,  4, 3, 1, 0};
    vecs[4]  = '{1, 7, 9, 9, 1,  7, 0, 0,  0, 0, 1, 0,  1, 6, 1, 0};
    vecs[5]  = '{1, 5, 0, 0, 3, 11, 0, 0,  0, 0, 0, 1,  0, 7, 0, 0};
    vecs[6]  = '{0, 5, 0, 0, 3,  3, 0, 0,  1, 0, 0, 0,  1, 6, 0, 0};
    vecs[7]  = '{1, 3, 5, 1, 3,  0, 6, 1,  0, 1, 0, 0,  1, 6, 0, 0};
    vecs[8]  = '{0, 3, 5, 1, 3,  9, 4, 1,  1, 0, 0, 0,  2, 5, 0, 0};
    vecs[9]  = '{0, 3, 5, 1, 1,  3, 15, 15, 0, 0, 1, 0, 3, 4, 1, 0};
    vecs[10] = '{1, 5, 2, 0, 0,  5, 9, 9,  0, 0, 1, 0,  1, 6, 1, 0};
    vecs[11] = '{1, 0, 0, 1, 3,  9, 9, 0,  1, 0, 0, 0,  1, 6, 0, 0};
    vecs[12] = '{0, 0, 0, 1, 3,  0, 0, 10, 0, 0, 0, 1,  1, 6, 0, 0};

    restart = 1'b1; secret_valid = 1'b0; confirm = 1'b0; max_digits = 2'd2;
    sd1 = 0; sd2 = 0; sd3 = 0; cd1 = 0; cd2 = 0; cd3 = 0;
    repeat (2) @(posedge clk);
    #1 restart = 1'b0;

    chk("rst_rv", rv0, 0);
    chk("rst_flags", {lo0, hi0, cor0, inv0}, 0);
    chk("rst_used", used0, 0);
    chk("rst_left", left0, 7);
    chk("rst_won_lost", {won0, lost0}, 0);
    chk("rst_busy", busy0, 0);
    do_guess(0, 0, 0, 0, lat, bw);
    chk("idle_ignores_confirm", lat, 0);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rst) load_secret(vecs[i].s1, vecs[i].s2, vecs[i].s3);
      max_digits = vecs[i].md;
      do_guess(vecs[i].g1, vecs[i].g2, vecs[i].g3, 0, lat, bw);
      chk($sformatf("v%0d_busy_wait", i), bw, 1);
      chk($sformatf("v%0d_latency", i), lat, 2);
      chk($sformatf("v%0d_flags_lo_hi_cor_inv", i), {lo0, hi0, cor0, inv0},
          {vecs[i].lo, vecs[i].hi, vecs[i].cor, vecs[i].inv});
      chk($sformatf("v%0d_used", i), used0, vecs[i].used);
      chk($sformatf("v%0d_left", i), left0, vecs[i].left);
      chk($sformatf("v%0d_won_lost", i), {won0, lost0}, {vecs[i].won, vecs[i].lost});
      @(posedge clk); #1;
      chk($sformatf("v%0d_rv_pulse", i), rv0, 0);
    end

    // Terminal WON freezes everything.
    load_secret(4, 2, 0);
    max_digits = 2'd2;
    do_guess(4, 2, 0, 0, lat, bw);
    chk("win_latency", lat, 2);
    do_guess(0, 3, 0, 0, lat, bw);
    chk("won_no_result", lat, 0);
    chk("won_used_frozen", used0, 1);
    chk("won_flags_frozen", {cor0, won0}, 2'b11);

    // Restart during the WAIT cycle.
    load_secret(4, 2, 0);
    do_guess(0, 3, 0, 0, lat, bw);
    chk("pre_restart_hi", hi0, 1);
    cd1 = 0; cd2 = 3; cd3 = 0;
    confirm = 1'b1;
    @(posedge clk); #1;
    confirm = 1'b0;
    chk("wait_busy", busy0, 1);
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    chk("rw_rv", rv0, 0);
    chk("rw_flags", {lo0, hi0, cor0, inv0}, 0);
    chk("rw_used", used0, 0);
    chk("rw_left", left0, 7);
    chk("rw_busy", busy0, 0);
    lat = 0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      if (rv0) lat = i;
    end
    chk("rw_no_late_result", lat, 0);
    do_guess(0, 3, 0, 0, lat, bw);
    chk("rw_idle_ignores", lat, 0);
    secret_valid = 1'b1;
    @(posedge clk); #1;
    secret_valid = 1'b0;
    do_guess(0, 3, 0, 0, lat, bw);
    chk("rw_after_secret_latency", lat, 2);
    chk("rw_after_secret_hi", hi0, 1);

    // Three-attempt instance: loss, then a win on the final attempt.
    load_secret(5, 0, 0);
    max_digits = 2'd1;
    do_guess(1, 0, 0, 1, lat, bw);
    do_guess(2, 0, 0, 1, lat, bw);
    chk("m3_not_lost_yet", lost3, 0);
    do_guess(3, 0, 0, 1, lat, bw);
    chk("m3_third_latency", lat, 2);
    chk("m3_lost", {won3, lost3}, 2'b01);
    chk("m3_left", left3, 0);
    chk("m3_used", used3, 3);
    chk("m3_lo", lo3, 1);
    do_guess(5, 0, 0, 1, lat, bw);
    chk("m3_lost_frozen", lat, 0);
    load_secret(5, 0, 0);
    do_guess(1, 0, 0, 1, lat, bw);
    do_guess(2, 0, 0, 1, lat, bw);
    do_guess(5, 0, 0, 1, lat, bw);
    chk("m3_final_win", {won3, lost3, cor3}, 3'b101);
    chk("m3_final_left", left3, 0);

`ifdef HINT_DISTANCE_EN
    load_secret(0, 5, 0);
    max_digits = 2'd2;
    do_guess(2, 4, 0, 0, lat, bw);
    chk("hot_42_lo", lo0, 1);
    chk("hot_42", hot0, 1);
    do_guess(9, 3, 0, 0, lat, bw);
    chk("hot_39_lo", lo0, 1);
    chk("hot_39", hot0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/guess_evaluator.md
Name: guess_evaluator

Overview:
- Consumer end of the guess-entry interface. It takes the confirm pulse and the locked-in compare digits produced by the player-input stage, and compares the guess against the latched secret number.
- Reports too-low, too-high or correct for each guess and counts attempts. Declares win or loss and drives the feedback/LED and game-flow logic.

Parameters:
- MAX_ATTEMPTS, 7, guesses allowed before loss (1..15)
- ATTEMPT_W, 4, width of attempt counters
- HOT_RANGE, 10, distance threshold for hot hint (HINT_DISTANCE_EN only)

Ports:
- clk  in  1  system clock
- restart  in  1  synchronous reset, active-high
- max_digits  in  2  active digit count (difficulty); 0 treated as 1
- secret_digit_1/2/3  in  4 each  secret BCD digits; digit_1 = ones, digit_2 = tens, digit_3 = hundreds
- secret_valid  in  1  secret digits valid; sampled only in IDLE
- confirm  in  1  player confirm pulse, same signal the input stage uses
- compare_digit_1/2/3  in  4 each  locked guess digits; valid one cycle after confirm
- result_valid  out  1  one-cycle pulse when a new result is registered
- too_low / too_high / correct  out  1 each  last result, one-hot or all zero; held until next result
- invalid_guess  out  1  last guess had a digit >9; held until next result
- attempts_used  out  ATTEMPT_W  guesses evaluated
- attempts_left  out  ATTEMPT_W  MAX_ATTEMPTS - attempts_used
- game_won / game_lost  out  1 each  terminal flags, sticky until restart
- busy  out  1  high in WAIT and COMPARE
- hot  out  1  HINT_DISTANCE_EN only

Behaviour:
- Reset (restart=1 at a clk edge):
  - state=IDLE
  - all flags 0, attempts_used=0, attempts_left=MAX_ATTEMPTS
  - latched secret and guess cleared
  - restart has priority over every other input, including mid-compare.
- States: IDLE, READY, WAIT, COMPARE, WON, LOST.
- IDLE:
  - secret_valid=1 → latch secret digits, go to READY.
  - confirm is ignored.
- READY:
  - confirm=1 at edge E0 → go to WAIT.
  - E0 is the same edge at which the input stage registers compare digits.
- WAIT (edge E1):
  - Latch compare_digit_1..3 into guess registers, go to COMPARE.
- COMPARE (edge E2):
  - Register result, pulse result_valid for the cycle after E2.
  - Latency: confirm sampled at E0 → result visible after E2.
- Masking: effective digits are those with index ≤ max(max_digits,1). Masked digits are forced to 0 in both guess and secret, so unused digits never affect the compare.
- Compare: lexicographic on (hundreds, tens, ones). This equals numeric order for legal BCD.
- Invalid guess: any effective guess digit >9 →
  - invalid_guess=1, too_low/too_high/correct=0
  - attempts_used not incremented
  - return to READY.
- Valid guess:
  - Exactly one of too_low/too_high/correct set; attempts_used++, attempts_left--.
  - correct → WON, game_won=1.
  - Otherwise, if new attempts_used==MAX_ATTEMPTS → LOST, game_lost=1.
  - Otherwise → READY.
- A correct guess on the final attempt gives WON, never LOST.
- WON/LOST:
  - Terminal; confirm and secret_valid ignored; outputs frozen until restart.
- confirm in WAIT/COMPARE is ignored; no queuing.
- A held confirm level re-triggers only after returning to READY.
- Counters never wrap: attempts_used saturates at MAX_ATTEMPTS, attempts_left saturates at 0.
- secret_valid outside IDLE is ignored. The secret is fixed for the round.

Optional Feature:
- HINT_DISTANCE_EN defined:
  - In COMPARE, convert effective guess and secret to binary (hundreds*100 + tens*10 + ones, 10 bits).
  - hot=1 when |guess-secret| ≤ HOT_RANGE and the result is not correct.
  - hot is registered with the other result flags, held until the next result, and reset to 0.
- Undefined:
  - hot port and conversion logic absent; all other behaviour identical.

Test Plan:
- restart, then secret 4/2/0 (value 24), max_digits=2, secret_valid, confirm with guess 0/3/0 (30) → result_valid exactly 2 edges after confirm edge, too_high=1, attempts_used=1, attempts_left=6.
- Same secret, guesses 10, 20, then 24 → too_low, too_low, correct; game_won=1; later confirm gives no result_valid and counters frozen.
- MAX_ATTEMPTS=3, secret 5, three wrong guesses → game_lost=1 after third, attempts_left=0. Rerun with correct on third → game_won=1, game_lost=0.
- max_digits=1, secret 7/9/9, guess 7/0/0 → correct=1 (upper digits masked).
- Guess digit_1=4'hB → invalid_guess=1, attempts_used unchanged, state back to READY, next valid guess evaluated.
- restart asserted in the WAIT cycle → no result_valid, all outputs at reset values next cycle, IDLE until secret_valid.
- HINT_DISTANCE_EN: secret 50, guess 42 → too_low=1, hot=1; guess 39 → hot=0.
